// File: rtl/nios2_jtag_debug_scan_master_pkg.sv
// Shared definitions for the Nios II JTAG debug scan master.
// Holds the default scan geometry, the virtual-IR instruction codes of the debug
// module and the scan sequencer state type.
package nios2_jtag_dbg_pkg;

  localparam int unsigned DEF_DR_WIDTH = 38;
  localparam int unsigned DEF_IR_WIDTH = 2;

  // Virtual IR instruction codes understood by the debug module.
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StRsp
  } scan_state_e;

endpackage

// File: rtl/nios2_jtag_debug_scan_master_if.sv
// Bus bundle for the scan master: command/response handshakes plus the
// virtual-JTAG signals towards the debug module.
//   master : the scan master (drives cmd_ready, rsp_*, vjm_* outputs)
//   slave  : the environment (drives cmd_*, rsp_ready, vjm_tdo, vjm_ir_out)
interface nios2_jtag_debug_scan_master_if
  import nios2_jtag_dbg_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
  parameter int unsigned IR_WIDTH = DEF_IR_WIDTH
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;
  logic                vjm_tck;
  logic                vjm_tdi;
  logic                vjm_tdo;
  logic [IR_WIDTH-1:0] vjm_ir_in;
  logic [IR_WIDTH-1:0] vjm_ir_out;
  logic                vjm_rti;
  logic                vjm_uir;
  logic                vjm_cdr;
  logic                vjm_sdr;
  logic                vjm_udr;

  modport master (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vjm_tdo, vjm_ir_out,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, vjm_tck, vjm_tdi, vjm_ir_in,
           vjm_rti, vjm_uir, vjm_cdr, vjm_sdr, vjm_udr
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vjm_tdo, vjm_ir_out,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, vjm_tck, vjm_tdi, vjm_ir_in,
           vjm_rti, vjm_uir, vjm_cdr, vjm_sdr, vjm_udr
  );

endinterface

// File: rtl/nios2_jtag_scan_tck_gen.sv
// tck generator for the scan master.
// While run_i is high, tck toggles every TCK_DIV clk cycles starting from the
// low half. Outside run_i, tck is forced low and the divider is cleared.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   run_i          : enable toggling
//   tck_o          : generated tck
//   tck_rise_o     : high in the cycle whose closing clk edge raises tck
//   tck_fall_o     : high in the cycle whose closing clk edge lowers tck
//   period_end_o   : high in the cycle that closes a full tck period
module nios2_jtag_scan_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic tck_o,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic period_end_o
);

  if (TCK_DIV == 0 || TCK_DIV > 255) begin : g_bad_div
    $error("nios2_jtag_scan_tck_gen: TCK_DIV must be in 1..255");
  end

  localparam logic [7:0] DivLast = 8'(TCK_DIV - 1);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       tck_q, tck_d;
  logic       toggle;

  always_comb begin
    toggle    = run_i && (div_cnt_q == DivLast);
    div_cnt_d = (!run_i || toggle) ? 8'd0 : div_cnt_q + 8'd1;
    tck_d     = run_i ? (tck_q ^ toggle) : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= 8'd0;
      tck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tck_q     <= tck_d;
    end
  end

  assign tck_o        = tck_q;
  assign tck_rise_o   = toggle & ~tck_q;
  assign tck_fall_o   = toggle & tck_q;
  // A period is low half then high half, so it closes on the falling edge.
  assign period_end_o = toggle & tck_q;

endmodule

// File: rtl/nios2_jtag_debug_scan_master.sv
// Virtual-JTAG scan master for the Nios II debug module.
// Accepts one command (IR + DR payload), walks UIR -> CDR -> SDR -> UDR with one
// tck period per state (DR_WIDTH periods in SDR), then presents the captured DR
// and the ir_out sampled in CDR until the response handshake completes.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : command/response handshakes and virtual-JTAG signals
module nios2_jtag_debug_scan_master
  import nios2_jtag_dbg_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
  parameter int unsigned IR_WIDTH = DEF_IR_WIDTH,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  nios2_jtag_debug_scan_master_if.master        bus
);

  localparam int unsigned CntW = $clog2(DR_WIDTH + 1);

  scan_state_e         state_q, state_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                tdi_q, tdi_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rti_q, rti_d;
  logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d;

  logic run, tck, tck_rise, tck_fall, period_end;

  assign run = (state_q != StIdle) && (state_q != StRsp);

  nios2_jtag_scan_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .run_i       (run),
    .tck_o       (tck),
    .tck_rise_o  (tck_rise),
    .tck_fall_o  (tck_fall),
    .period_end_o(period_end)
  );

  always_comb begin
    state_d     = state_q;
    ir_in_d     = ir_in_q;
    rsp_ir_d    = rsp_ir_q;
    sr_d        = sr_q;
    rsp_dr_d    = rsp_dr_q;
    bit_cnt_d   = bit_cnt_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          ir_in_d   = bus.cmd_ir;
          sr_d      = bus.cmd_dr;
          bit_cnt_d = '0;
          state_d   = StUir;
        end
      end
      StUir: begin
        if (period_end) state_d = StCdr;
      end
      StCdr: begin
        if (tck_rise) rsp_ir_d = bus.vjm_ir_out;
        if (period_end) begin
          state_d = StSdr;
          tdi_d   = sr_q[0];
        end
      end
      StSdr: begin
        if (tck_rise) begin
          sr_d      = {bus.vjm_tdo, sr_q[DR_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
        if (tck_fall) tdi_d = sr_q[0];
        if (period_end && (bit_cnt_q == CntW'(DR_WIDTH))) begin
          state_d = StUdr;
          tdi_d   = 1'b0;
        end
      end
      StUdr: begin
        if (period_end) begin
          state_d     = StRsp;
          rsp_dr_d    = sr_q;
          rsp_valid_d = 1'b1;
        end
      end
      StRsp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes and ready are registered from the next state so they line up with it.
    cmd_ready_d = (state_d == StIdle);
    rti_d       = (state_d == StIdle);
    uir_d       = (state_d == StUir);
    cdr_d       = (state_d == StCdr);
    sdr_d       = (state_d == StSdr);
    udr_d       = (state_d == StUdr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ir_in_q     <= '0;
      rsp_ir_q    <= '0;
      sr_q        <= '0;
      rsp_dr_q    <= '0;
      bit_cnt_q   <= '0;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      rti_q       <= 1'b1;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_in_q     <= ir_in_d;
      rsp_ir_q    <= rsp_ir_d;
      sr_q        <= sr_d;
      rsp_dr_q    <= rsp_dr_d;
      bit_cnt_q   <= bit_cnt_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      rti_q       <= rti_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dr     = rsp_dr_q;
  assign bus.rsp_ir_out = rsp_ir_q;
  assign bus.vjm_tck    = tck;
  assign bus.vjm_tdi    = tdi_q;
  assign bus.vjm_ir_in  = ir_in_q;
  assign bus.vjm_rti    = rti_q;
  assign bus.vjm_uir    = uir_q;
  assign bus.vjm_cdr    = cdr_q;
  assign bus.vjm_sdr    = sdr_q;
  assign bus.vjm_udr    = udr_q;

endmodule

// File: doc/nios2_jtag_debug_scan_master.md
Name: nios2_jtag_debug_scan_master

Overview:
Clock-domain initiator for the Nios II JTAG debug module's virtual-JTAG interface. It replaces the virtual-JTAG hub so on-chip logic or a testbench can drive debug scans without a physical JTAG cable. It accepts one command at a time, holding a 2-bit IR and a 38-bit DR payload. It generates tck, ir_in and the UIR/CDR/SDR/UDR virtual-state strobes, shifts tdi out, captures tdo, and returns the captured DR and ir_out.

Parameters:
DR_WIDTH, 38, DR shift length in bits (matches debug-module jdo/sr width)
IR_WIDTH, 2, virtual IR width
TCK_DIV, 2, tck half-period in clk cycles; legal range 1..255

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block idle, command accepted when valid&ready
cmd_ir  in  IR_WIDTH  IR value to load (00 ocimem, 01 tracemem, 10 break, 11 tracectrl)
cmd_dr  in  DR_WIDTH  DR data shifted out LSB first
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready
rsp_dr  out  DR_WIDTH  captured tdo bits, bit 0 = first bit shifted
rsp_ir_out  out  IR_WIDTH  ir_out sampled during CDR
vjm_tck  out  1  generated tck
vjm_tdi  out  1  serial data to responder
vjm_tdo  in  1  serial data from responder
vjm_ir_in  out  IR_WIDTH  current virtual IR
vjm_ir_out  in  IR_WIDTH  responder status IR
vjm_rti  out  1  run-test-idle indication
vjm_uir, vjm_cdr, vjm_sdr, vjm_udr  out  1 each  virtual-state strobes

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset_n is asynchronous and active-low. Clock port is clk, reset port is reset_n.
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0.
  - vjm_tck=0, vjm_tdi=0, vjm_ir_in=0, vjm_rti=1, all strobes 0.
- tck generation:
  - A half-period counter toggles vjm_tck every TCK_DIV clk cycles, but only outside IDLE and RSP.
  - Each "tck period" is 2*TCK_DIV clk cycles: low half first, then high half.
- States: IDLE, UIR, CDR, SDR, UDR, RSP.
  - IDLE: rti=1, cmd_ready=1. On cmd_valid, latch cmd_ir into vjm_ir_in and cmd_dr into the shift register, clear bit counter, go to UIR on the next clk.
  - UIR: uir=1 for 1 tck period, then CDR.
  - CDR: cdr=1 for 1 tck period. On the tck rising edge, sample vjm_ir_out into rsp_ir_out. Then SDR.
  - SDR: sdr=1 for exactly DR_WIDTH tck periods.
    - At each falling edge (including SDR entry), vjm_tdi = sr[0].
    - At each rising edge, sr <= {vjm_tdo, sr[DR_WIDTH-1:1]}, bit counter++.
    - Leave after counter reaches DR_WIDTH.
  - UDR: udr=1 for 1 tck period, then RSP.
  - RSP: tck held 0, tdi 0, rsp_dr=sr, rsp_valid=1. Stay until rsp_ready; on the handshake return to IDLE with rsp_valid=0 the next cycle.
- Strobes: exactly one strobe is high outside IDLE and RSP; none in IDLE or RSP. vjm_ir_in holds its value until the next accepted command.
- Latency: rsp_valid rises exactly (DR_WIDTH+3)*2*TCK_DIV clk cycles after the accepting edge. Defaults give 164 cycles.
- tck edge count: exactly DR_WIDTH+3 rising edges per command (41 at default).
- Busy: cmd_ready=0 from the accepting edge until the RSP handshake. cmd_valid while busy is ignored; the command is not queued.
- Backpressure: rsp_dr and rsp_ir_out remain stable while rsp_valid=1 and rsp_ready=0.
- Simultaneous events: the RSP handshake and a new cmd_valid in the same cycle are not merged. The new command is accepted only once in IDLE, one cycle later.
- Reset mid-operation: asynchronous return to reset values. No partial response is produced; tck drops low immediately.
- TCK_DIV=0 is illegal; a simulation assertion fires.

Decomposition:
- Shared package nios2_jtag_dbg_pkg:
  - IR code constants: IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3.
  - DR_WIDTH and IR_WIDTH defaults.
  - Scan state enum.
- One sub-module: nios2_jtag_scan_tck_gen.
  - Contains the divider counter and run enable.
  - Outputs vjm_tck plus single-cycle tck_rise and tck_fall pulses and period_end.
  - Consumed by the FSM.

Test Plan:
- Reset check: assert reset_n=0 for 3 cycles -> cmd_ready=1, rti=1, tck=0, all strobes 0, rsp_valid=0.
- Loopback scan: tdo model returns DR 38'h15_A5A5_5A5A and ir_out=2'b10; send cmd_ir=2'b01, cmd_dr=38'h2A_1234_5678, TCK_DIV=2.
  - rsp_valid exactly 164 cycles after acceptance.
  - rsp_dr=38'h15_A5A5_5A5A, rsp_ir_out=2'b10.
  - Model received 38'h2A_1234_5678 LSB first; vjm_ir_in=2'b01.
- Edge and strobe count: TCK_DIV=1 -> 41 tck rises; uir, cdr and udr each high 2 cycles; sdr high 76 cycles; no overlap.
- Backpressure: hold rsp_ready=0 for 20 cycles -> rsp_valid and rsp_dr stable, tck stays 0, cmd_ready=0. A cmd_valid pulse during this window is dropped: no second scan occurs.
- Reset mid-SDR: drop reset_n after the 10th SDR rise -> outputs return to reset values immediately. After release, a new command completes correctly with no stale rsp_valid.
- Back-to-back: two commands with rsp_ready=1 -> second accepted exactly 1 cycle after the first RSP handshake, and both responses are correct.
